// File: rtl/ram_nr1w_pkg.sv
// Shared constants and address-translation helpers for the multi-read-port data RAM.
// The helpers take the geometry as arguments so every instance can reuse them.
package ram_pkg;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int          OFF_BITS          = $clog2(64 / 8);

  // Word index of a byte offset; off_bits is log2 of the word size in bytes.
  function automatic logic [63:0] idx_of(input logic [63:0] off, input int off_bits);
    return off >> off_bits;
  endfunction

  function automatic logic in_range(input logic [63:0] idx, input int depth);
    return idx < 64'(depth);
  endfunction

endpackage

// File: rtl/ram_nr1w_rd_port.sv
// One read port: address decode, write-first forwarding merge, optional
// instruction-half select and the registered response.
module ram_rd_port
  import ram_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 4096,
  parameter int          ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter bit          IPORT     = 1'b0,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              wr_hit_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DATA_W-1:0] rd_data
);

  localparam int                OB   = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  logic [ADDR_W-1:0] off;
  logic [63:0]       idx_full;
  logic              in_rng;
  logic              fwd;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] sel_word;

  logic              valid_d, valid_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] data_d, data_q;

  assign off      = rd_addr - BASE;
  assign idx_full = idx_of(64'(off), OB);
  assign in_rng   = in_range(idx_full, DEPTH);
  assign rd_idx   = idx_full[IDX_W-1:0];

  // A same-cycle write to this index is merged in so the port sees post-write data.
  assign fwd  = wr_hit_en && (wr_idx == rd_idx);
  assign word = fwd ? ((mem_word & ~wr_mask) | (wr_data & wr_mask)) : mem_word;

  generate
    if (IPORT && (DATA_W > 32)) begin : g_iport
      assign sel_word = {{(DATA_W-32){1'b0}}, (rd_addr[2] ? word[63:32] : word[31:0])};
    end else begin : g_plain
      assign sel_word = word;
    end
  endgenerate

  always_comb begin
    valid_d = rd_en;
    err_d   = rd_en && !in_rng;
    data_d  = data_q;
    if (rd_en) begin
      data_d = in_rng ? sel_word : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_err   = err_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/ram_nr1w.sv
// Data memory with NUM_RD registered read ports and one bit-masked write port.
// The top owns the array and the write decode; each read port is a ram_rd_port.
module ram_nr1w
  import ram_pkg::*;
#(
  parameter int          DATA_W     = 64,
  parameter int          DEPTH      = 4096,
  parameter int          NUM_RD     = 2,
  parameter int          ADDR_W     = 64,
  parameter logic [63:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          IPORT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_err,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        wr_mask,
  output logic                     wr_err
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam int                OB    = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_off;
  logic [63:0]       wr_idx_full;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_ok;
  logic              wr_err_d, wr_err_q;

  assign wr_off      = wr_addr - BASE;
  assign wr_idx_full = idx_of(64'(wr_off), OB);
  assign wr_idx      = wr_idx_full[IDX_W-1:0];
  assign wr_ok       = wr_en && in_range(wr_idx_full, DEPTH);

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_comb begin
    wr_err_d = wr_en && !wr_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] word;

      assign word = mem[idx];

      ram_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .IPORT    ((IPORT_MODE != 0) && (gi == 0))
      ) u_port (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en[gi]),
        .rd_addr  (rd_addr[gi*ADDR_W +: ADDR_W]),
        .rd_idx   (idx),
        .mem_word (word),
        .wr_hit_en(wr_ok),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .rd_valid (rd_valid[gi]),
        .rd_err   (rd_err[gi]),
        .rd_data  (rd_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ram_nr1w.sv
// Randomised plus directed bench for ram_nr1w against a word-array reference model.
module tb_ram_nr1w;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   rd_en;
  logic [127:0] rd_addr;
  logic [1:0]   rd_valid;
  logic [127:0] rd_data;
  logic [1:0]   rd_err;
  logic         wr_en;
  logic [63:0]  wr_addr;
  logic [63:0]  wr_data;
  logic [63:0]  wr_mask;
  logic         wr_err;

  ram_nr1w dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mask (wr_mask),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  logic [63:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [63:0] prev_data [2];
  bit          prev_kn [2];
  int          checks = 0;
  int          failures = 0;
  int          txn = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng_m(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (off / 8) < DEPTH;
  endfunction

  function automatic int idx_m(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return int'((off / 8) % DEPTH);
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
    else a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
    return a;
  endfunction

  // One clock of stimulus; expectations come from the model before the edge.
  task automatic step(input logic [1:0] ren, input logic [63:0] a0, input logic [63:0] a1,
                      input logic we, input logic [63:0] wa, input logic [63:0] wd,
                      input logic [63:0] wm);
    logic [63:0] addr_l [2];
    logic [63:0] exp_data [2];
    bit          exp_kn [2];
    bit          exp_err [2];
    logic [63:0] word;
    bit          kn;
    bit          w_in;
    int          w_idx;
    int          i;
    addr_l[0] = a0;
    addr_l[1] = a1;
    rd_en   = ren;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_mask = wm;
    w_in  = we && in_rng_m(wa);
    w_idx = idx_m(wa);
    for (int p = 0; p < 2; p++) begin
      exp_data[p] = prev_data[p];
      exp_kn[p]   = prev_kn[p];
      exp_err[p]  = 1'b0;
      if (ren[p]) begin
        if (in_rng_m(addr_l[p])) begin
          i    = idx_m(addr_l[p]);
          word = mem_m[i];
          kn   = known_m[i];
          if (w_in && w_idx == i) begin
            word = (word & ~wm) | (wd & wm);
            kn   = kn || (wm == ONES);
          end
          if (p == 0) word = addr_l[p][2] ? {32'h0, word[63:32]} : {32'h0, word[31:0]};
          exp_data[p] = word;
          exp_kn[p]   = kn;
        end else begin
          exp_data[p] = 64'h0;
          exp_kn[p]   = 1'b1;
          exp_err[p]  = 1'b1;
        end
      end
    end
    if (w_in) begin
      mem_m[w_idx] = (mem_m[w_idx] & ~wm) | (wd & wm);
      if (wm == ONES) known_m[w_idx] = 1'b1;
    end
    $display("txn %0d ren=%b a0=%h a1=%h we=%b wa=%h wd=%h wm=%h", txn, ren, a0, a1, we, wa, wd, wm);
    txn++;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("valid%0d", p), 64'(rd_valid[p]), 64'(ren[p]));
      if (ren[p]) chk($sformatf("err%0d", p), 64'(rd_err[p]), 64'(exp_err[p]));
      if (exp_kn[p]) chk($sformatf("data%0d", p), rd_data[p*64 +: 64], exp_data[p]);
      prev_data[p] = exp_data[p];
      prev_kn[p]   = exp_kn[p];
    end
    chk("wr_err", 64'(wr_err), 64'(we && !in_rng_m(wa)));
  endtask

  task automatic wr(input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] wm);
    step(2'b00, 64'h0, 64'h0, 1'b1, wa, wd, wm);
  endtask

  task automatic rd(input logic [1:0] ren, input logic [63:0] a0, input logic [63:0] a1);
    step(ren, a0, a1, 1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    rd_en = 2'b00; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      known_m[i] = 1'b0;
      mem_m[i]   = 64'h0;
    end
    for (int p = 0; p < 2; p++) begin
      prev_data[p] = 64'h0;
      prev_kn[p]   = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rd_valid), 64'h0);
    chk("rst_err", 64'(rd_err), 64'h0);
    chk("rst_data0", rd_data[63:0], 64'h0);
    chk("rst_data1", rd_data[127:64], 64'h0);
    chk("rst_wr_err", 64'(wr_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) wr(BASE + 64'(8 * i), {$urandom, $urandom}, ONES);
    wr(BASE + 64'h7FF8, 64'hCAFE_F00D_1234_5678, ONES);

    // Base write, then read-back on port 1.
    wr(64'h8000_0008, 64'h1122_3344_5566_7788, ONES);
    rd(2'b10, 64'h0, 64'h8000_0008);
    chk("plan_base", rd_data[127:64], 64'h1122_3344_5566_7788);
    // Partial mask.
    wr(64'h8000_0008, ONES, 64'h0000_0000_FFFF_0000);
    rd(2'b10, 64'h0, 64'h8000_0008);
    chk("plan_mask", rd_data[127:64], 64'h1122_3344_FFFF_7788);
    // Forwarding on both ports.
    wr(64'h8000_0010, 64'h0123_4567_89AB_CDEF, ONES);
    step(2'b11, 64'h8000_0010, 64'h8000_0010, 1'b1, 64'h8000_0010, 64'hA5, 64'hFF);
    chk("plan_fwd1", rd_data[127:64], 64'h0123_4567_89AB_CDA5);
    chk("plan_fwd0", rd_data[63:0], 64'h0000_0000_89AB_CDA5);
    // Instruction mode.
    wr(64'h8000_0000, 64'hDEAD_BEEF_0000_0013, ONES);
    rd(2'b01, 64'h8000_0000, 64'h0);
    chk("plan_ilo", rd_data[63:0], 64'h13);
    rd(2'b01, 64'h8000_0004, 64'h0);
    chk("plan_ihi", rd_data[63:0], 64'hDEAD_BEEF);
    // Range checks.
    rd(2'b10, 64'h0, 64'h7FFF_FFF8);
    chk("plan_lo_err", 64'(rd_err[1]), 64'h1);
    wr(64'h8000_8000, ONES, ONES);
    rd(2'b10, 64'h0, 64'h8000_0000);
    chk("plan_oob_wr", rd_data[127:64], 64'hDEAD_BEEF_0000_0013);
    rd(2'b11, 64'h8000_7FFC, 64'h8000_7FF8);
    chk("plan_top_err", 64'(rd_err), 64'h0);

    for (int n = 0; n < 300; n++) begin
      logic [63:0] wm;
      case ($urandom_range(0, 2))
        0:       wm = ONES;
        1:       wm = {$urandom, $urandom};
        default: wm = 64'h0;
      endcase
      step(2'($urandom_range(0, 3)), rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
           rand_addr(), {$urandom, $urandom}, wm);
    end

    // Reset coincident with a read request drops it.
    rd_en   = 2'b11;
    rd_addr = {BASE + 64'h8, BASE};
    wr_en   = 1'b0;
    rst     = 1'b1;
    #1;
    chk("arst_valid", 64'(rd_valid), 64'h0);
    chk("arst_data0", rd_data[63:0], 64'h0);
    chk("arst_data1", rd_data[127:64], 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold", 64'(rd_valid), 64'h0);
    rd_en = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_drop", 64'(rd_valid), 64'h0);
    for (int p = 0; p < 2; p++) begin
      prev_data[p] = 64'h0;
      prev_kn[p]   = 1'b1;
    end
    rd(2'b11, BASE + 64'h8, BASE + 64'h8);
    chk("post_rst", rd_data[127:64], mem_m[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_nr1w.md
# ram_nr1w

Parametrised synthesizable data memory for the single-cycle/pipelined core, successor to the two-read/one-write simulation RAM. Provides `NUM_RD` independent read ports with one-cycle registered latency, one bit-masked write port, physical-to-index translation from `BASE_ADDR`, out-of-range detection, and same-cycle write-to-read forwarding. Port 0 can run in instruction mode, returning the 32-bit half selected by `addr[2]`.

## Interface
- `DATA_W`, default 64: word width in bits. Must be a power of two and at least 32.
- `DEPTH`, default 4096: number of words. Must be a power of two.
- `NUM_RD`, default 2: number of read ports, 1 to 4.
- `ADDR_W`, default 64: byte-address width.
- `BASE_ADDR`, default 64'h0000_0000_8000_0000: byte address of word 0.
- `IPORT_MODE`, default 1: when 1, port 0 returns a zero-extended 32-bit instruction.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rd_en`, input, `NUM_RD`: per-port read request.
- `rd_addr`, input, `NUM_RD*ADDR_W`: per-port byte address. Port i occupies slice i.
- `rd_valid`, output, `NUM_RD`: response valid, one cycle after the request.
- `rd_data`, output, `NUM_RD*DATA_W`: response data.
- `rd_err`, output, `NUM_RD`: response refers to an out-of-range address.
- `wr_en`, input, 1: write request.
- `wr_addr`, input, `ADDR_W`: write byte address.
- `wr_data`, input, `DATA_W`: write data.
- `wr_mask`, input, `DATA_W`: per-bit write enable.
- `wr_err`, output, 1: registered flag, high for one cycle after an out-of-range write.

## Operation
- Index translation:
  - `off = addr - BASE_ADDR`, computed modulo 2^`ADDR_W`.
  - `idx = off >> log2(DATA_W/8)`. The low offset bits are ignored, so accesses are word-aligned.
  - An address is in range only when `off >> log2(DATA_W/8) < DEPTH`. Addresses below `BASE_ADDR` wrap to large offsets and are out of range.
- Write:
  - When `wr_en` is high and the address is in range: `mem[idx] <= (mem[idx] & ~wr_mask) | (wr_data & wr_mask)` at the clock edge.
  - When the address is out of range, the array is unchanged and `wr_err` is 1 in the next cycle.
- Read:
  - When `rd_en[i]` is high, port i captures the word at the edge.
  - In the next cycle `rd_valid[i]` = 1 and `rd_data[i]` = the captured word.
  - When `rd_en[i]` is low, `rd_valid[i]` = 0 the next cycle and `rd_data[i]` holds its previous value.
  - Out-of-range read: `rd_valid` = 1, `rd_err` = 1, `rd_data` = 0.
- Forwarding: a read and a write to the same in-range index in the same cycle returns the merged, post-write word (write-first). Every port applies this independently.
- Instruction mode (port 0, `IPORT_MODE` = 1): `rd_data[0]` = {zeros, `addr[2]` ? word[63:32] : word[31:0]}. The `addr[2]` value used is the one registered with the request. The `DATA_W` = 32 configuration ignores `addr[2]`.
- Array contents are not reset. Contents after power-up are undefined.
- Multiple ports may read the same index in the same cycle with no penalty.

## Timing
- Read latency is exactly 1 cycle, with no stalls and no backpressure. A new request may be issued on every port every cycle.
- Write takes effect at the edge. A read of the same index issued in the following cycle sees the new data.
- Reset values: `rd_valid` = 0, `rd_err` = 0, `rd_data` = 0, `wr_err` = 0. Reset applies immediately, asynchronously.
- Reset mid-operation:
  - A request captured in the cycle reset asserts is dropped, with no valid pulse after deassertion.
  - A write coincident with reset assertion may or may not land in the array. Verification must not check it.
- First request is accepted on the first rising edge after `rst` deasserts.

## Structure
- `ram_pkg` holds:
  - the default `BASE_ADDR`;
  - the `idx_of` and `in_range` functions, parameterised by `DATA_W` and `DEPTH`;
  - the `$clog2`-based `OFF_BITS` constant.
- Sub-module `ram_rd_port`: one instance per read port, created by generate. It contains:
  - the address decode;
  - the forwarding merge;
  - the response registers;
  - the instruction-half select, enabled for port 0 only.
- The top level owns the memory array and the write decode.

## Test plan
- Base write and read-back: write 64'h1122_3344_5566_7788 to 0x8000_0008 with full mask. Read port 1 from 0x8000_0008 in the next cycle. Expect `rd_data[1]` = 64'h1122_3344_5566_7788 with `rd_valid` = 1 one cycle later.
- Partial mask: from the prior word, write 64'hFFFF_FFFF_FFFF_FFFF with mask 64'h0000_0000_FFFF_0000. Read back 64'h1122_3344_FFFF_7788.
- Forwarding: in one cycle, write 64'hA5 with mask 64'hFF to 0x8000_0010 and read the same address on both ports. Expect both ports to return low byte 8'hA5 after 1 cycle, with upper bits equal to the prior contents.
- Instruction mode: with the word 64'hDEAD_BEEF_0000_0013 at 0x8000_0000, read port 0 at 0x8000_0000 and expect 64'h13. Read port 0 at 0x8000_0004 and expect 64'hDEAD_BEEF.
- Range checks, all with `DEPTH` = 4096:
  - Read 0x7FFF_FFF8: `rd_err` = 1, data 0.
  - Write 0x8000_8000: `wr_err` = 1 and a read of index 0 is unchanged.
  - Read 0x8000_7FF8: `rd_err` = 0.
- Reset: issue a read, assert `rst` in the same cycle, and expect `rd_valid` to stay 0. Read outputs are 0 while reset is asserted. The first read after deassertion completes in 1 cycle.
